// File: rtl/csr_diag_pkg.sv
// Shared types and default sizing for the CSR diagonal-check scheduler.
// Pure declarations; no logic, no latency, no flow control.
package csr_diag_pkg;

  localparam int WIDTH_D  = 10;
  localparam int ADDR_W_D = 12;
  localparam int NREQ_D   = 4;
  localparam int ID_W_D   = 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_OFF,
    FETCH_COL,
    DRAIN,
    REPORT
  } state_t;

  typedef struct packed {
    logic [ADDR_W_D-1:0] base_off;
    logic [ADDR_W_D-1:0] base_col;
    logic [WIDTH_D-1:0]  num_row;
    logic [WIDTH_D-1:0]  nnz;
  } desc_t;

endpackage

// File: rtl/csr_diag_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant and index, zero latency.
// The priority pointer moves past the winner only when adv is high.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] j;
  logic            found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = ID_W'((int'(ptr) + i) % NREQ);
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (adv && found) begin
      ptr <= (idx == ID_W'(NREQ - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/csr_diag_sched.sv
// Streams offsets then colIdx from memory per granted request and checks +1 steps.
// Done at T+R+N+2 (T+1 if empty, D+1 on mismatch); requests wait while busy.
module csr_diag_sched
  import csr_diag_pkg::*;
#(
  parameter int WIDTH  = WIDTH_D,
  parameter int NREQ   = NREQ_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int ID_W   = ID_W_D
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_base_off,
  input  logic [NREQ*ADDR_W-1:0] req_base_col,
  input  logic [NREQ*WIDTH-1:0]  req_num_row,
  input  logic [NREQ*WIDTH-1:0]  req_nnz,
  output logic [NREQ-1:0]        gnt,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [WIDTH-1:0]       mem_rd_data,
  output logic                   busy,
  output logic                   done,
  output logic                   flag,
  output logic [ID_W-1:0]        done_id
);

  state_t           state;
  desc_t            desc;
  desc_t            sel;
  logic [NREQ-1:0]  arb_gnt;
  logic [ID_W-1:0]  arb_idx;
  logic [ID_W-1:0]  cur_id;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] phase_cnt;
  logic [WIDTH:0]   diff;
  logic             start, fetch, last, mism;
  logic             flag_acc, prev_vld, prev_ph, rd_pend, rd_ph;

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .adv (start),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    sel.base_off = req_base_off[arb_idx*ADDR_W +: ADDR_W];
    sel.base_col = req_base_col[arb_idx*ADDR_W +: ADDR_W];
    sel.num_row  = req_num_row[arb_idx*WIDTH +: WIDTH];
    sel.nnz      = req_nnz[arb_idx*WIDTH +: WIDTH];
  end

  assign start = (state == IDLE) && (|req);
  assign gnt   = start ? arb_gnt : '0;
  assign busy  = (state != IDLE) || start;

  assign fetch     = (state == FETCH_OFF) || (state == FETCH_COL);
  assign phase_cnt = (state == FETCH_COL) ? desc.nnz : desc.num_row;
  assign last      = (cnt == phase_cnt - 1'b1);

  // Zero-extended subtract so a wrap from all-ones to zero is a mismatch.
  assign diff = {1'b0, mem_rd_data} - {1'b0, prev};
  assign mism = rd_pend && prev_vld && (prev_ph == rd_ph) && (diff != (WIDTH+1)'(1));

  assign mem_rd_en = fetch && !mism;
  assign mem_addr  = ((state == FETCH_COL) ? desc.base_col : desc.base_off) + ADDR_W'(cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      desc     <= '0;
      cur_id   <= '0;
      cnt      <= '0;
      prev     <= '0;
      flag_acc <= 1'b1;
      prev_vld <= 1'b0;
      prev_ph  <= 1'b0;
      rd_pend  <= 1'b0;
      rd_ph    <= 1'b0;
      done     <= 1'b0;
      flag     <= 1'b1;
      done_id  <= '0;
    end else begin
      done    <= 1'b0;
      rd_pend <= mem_rd_en;
      rd_ph   <= (state == FETCH_COL);
      if (rd_pend) begin
        prev     <= mem_rd_data;
        prev_vld <= 1'b1;
        prev_ph  <= rd_ph;
      end
      case (state)
        IDLE: begin
          if (start) begin
            desc     <= sel;
            cur_id   <= arb_idx;
            flag_acc <= 1'b1;
            prev_vld <= 1'b0;
            cnt      <= '0;
            if (sel.num_row != '0) begin
              state <= FETCH_OFF;
            end else if (sel.nnz != '0) begin
              state <= FETCH_COL;
            end else begin
              state   <= REPORT;
              done    <= 1'b1;
              flag    <= 1'b1;
              done_id <= arb_idx;
            end
          end
        end
        FETCH_OFF, FETCH_COL, DRAIN: begin
          if (mism) begin
            flag_acc <= 1'b0;
            state    <= REPORT;
            done     <= 1'b1;
            flag     <= 1'b0;
            done_id  <= cur_id;
          end else if (state == DRAIN) begin
            state   <= REPORT;
            done    <= 1'b1;
            flag    <= flag_acc;
            done_id <= cur_id;
          end else if (last) begin
            cnt <= '0;
            if (state == FETCH_OFF && desc.nnz != '0) state <= FETCH_COL;
            else                                      state <= DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REPORT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_diag_sched.sv
// Directed bench for csr_diag_sched: memory model, read/grant monitors, immediate-assert checks.
module tb_csr_diag_sched;

  localparam int WIDTH  = 10;
  localparam int NREQ   = 4;
  localparam int ADDR_W = 12;
  localparam int ID_W   = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_base_off;
  logic [NREQ*ADDR_W-1:0] req_base_col;
  logic [NREQ*WIDTH-1:0]  req_num_row;
  logic [NREQ*WIDTH-1:0]  req_nnz;
  logic [NREQ-1:0]        gnt;
  logic                   mem_rd_en;
  logic [ADDR_W-1:0]      mem_addr;
  logic [WIDTH-1:0]       mem_rd_data = '0;
  logic                   busy, done, flag;
  logic [ID_W-1:0]        done_id;

  logic [WIDTH-1:0] mem [0:4095];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int viol = 0;
  int rd_a[$];
  int rd_c[$];
  logic busy_q = 1'b0;
  logic done_q = 1'b0;

  csr_diag_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_base_off (req_base_off),
    .req_base_col (req_base_col),
    .req_num_row  (req_num_row),
    .req_nnz      (req_nnz),
    .gnt          (gnt),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .busy         (busy),
    .done         (done),
    .flag         (flag),
    .done_id      (done_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_rd_en) begin
      rd_a.push_back(int'(mem_addr));
      rd_c.push_back(cyc);
    end
    if (gnt != '0 && busy_q && !done_q) viol = viol + 1;
    if (gnt != '0 && !$onehot(gnt))     viol = viol + 1;
    busy_q <= busy;
    done_q <= done;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    n_chk = n_chk + 1;
    assert (obs === expv) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic set_desc(input int i, input int boff, input int bcol, input int r, input int n);
    req_base_off[i*ADDR_W +: ADDR_W] = ADDR_W'(boff);
    req_base_col[i*ADDR_W +: ADDR_W] = ADDR_W'(bcol);
    req_num_row[i*WIDTH +: WIDTH]    = WIDTH'(r);
    req_nnz[i*WIDTH +: WIDTH]        = WIDTH'(n);
  endtask

  // Single request: returns grant cycle, done cycle, flag, id and busy one cycle after done.
  task automatic run_one(input int id, output int t_g, output int t_d, output logic f,
                         output logic [ID_W-1:0] did, output logic ba);
    t_g = -1; t_d = -1; f = 1'bx; did = 'x; ba = 1'bx;
    @(posedge clk); #1;
    rd_a.delete(); rd_c.delete();
    req[id] = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (t_g >= 0 && cyc > t_g) req[id] = 1'b0;
      if (gnt[id] && t_g < 0) t_g = cyc;
      if (done) begin
        t_d = cyc; f = flag; did = done_id;
        break;
      end
    end
    req[id] = 1'b0;
    @(negedge clk);
    ba = busy;
  endtask

  int tg, td, ng, nd, tg5, dcount;
  logic fl, ba;
  logic [ID_W-1:0] di;
  int gv[5];
  int dv[5];
  int fv[5];
  int tgv[2];
  int tdv[2];
  int exp_a[7];

  initial begin
    req = '0; req_base_off = '0; req_base_col = '0; req_num_row = '0; req_nnz = '0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_flag", 32'(flag), 1);
    chk("rst_done_id", 32'(done_id), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic full pass on requester 0.
    for (int i = 0; i < 4; i++) mem[i] = WIDTH'(i);
    mem[16] = 10'd5; mem[17] = 10'd6; mem[18] = 10'd7;
    set_desc(0, 0, 16, 4, 3);
    run_one(0, tg, td, fl, di, ba);
    chk("A_latency", 32'(td - tg), 9);
    chk("A_flag", 32'(fl), 1);
    chk("A_id", 32'(di), 0);
    chk("A_busy_after", 32'(ba), 0);
    chk("A_nreads", 32'(rd_a.size()), 7);
    exp_a = '{0, 1, 2, 3, 16, 17, 18};
    for (int i = 0; i < 7 && i < rd_a.size(); i++) begin
      chk("A_addr", 32'(rd_a[i]), exp_a[i]);
      chk("A_rd_cycle", 32'(rd_c[i] - tg), 1 + i);
    end

    // Mismatch on third offset word: data at T+4, done at T+5, colIdx never read.
    mem[32] = 10'd0; mem[33] = 10'd1; mem[34] = 10'd3; mem[35] = 10'd4;
    set_desc(1, 32, 48, 4, 5);
    run_one(1, tg, td, fl, di, ba);
    chk("B_latency", 32'(td - tg), 5);
    chk("B_flag", 32'(fl), 0);
    chk("B_id", 32'(di), 1);
    chk("B_nreads", 32'(rd_a.size()), 3);
    if (rd_a.size() > 2) chk("B_last_addr", 32'(rd_a[2]), 34);

    // R=0, N=1.
    mem[64] = 10'd9;
    set_desc(2, 200, 64, 0, 1);
    run_one(2, tg, td, fl, di, ba);
    chk("C_latency", 32'(td - tg), 3);
    chk("C_flag", 32'(fl), 1);
    chk("C_id", 32'(di), 2);
    chk("C_nreads", 32'(rd_a.size()), 1);
    if (rd_a.size() > 0) chk("C_addr", 32'(rd_a[0]), 64);

    // R=N=0.
    set_desc(3, 300, 400, 0, 0);
    run_one(3, tg, td, fl, di, ba);
    chk("D_latency", 32'(td - tg), 1);
    chk("D_flag", 32'(fl), 1);
    chk("D_id", 32'(di), 3);
    chk("D_nreads", 32'(rd_a.size()), 0);

    // Address wrap 4095 -> 0 is legal.
    mem[4095] = 10'd200; mem[0] = 10'd201;
    set_desc(0, 4095, 0, 2, 0);
    run_one(0, tg, td, fl, di, ba);
    chk("AW_flag", 32'(fl), 1);
    chk("AW_latency", 32'(td - tg), 4);
    if (rd_a.size() > 1) chk("AW_addr1", 32'(rd_a[1]), 0);

    // Phase boundary: first colIdx word is not compared to the last offset word.
    mem[110] = 10'd5; mem[111] = 10'd6; mem[120] = 10'd0; mem[121] = 10'd1;
    set_desc(1, 110, 120, 2, 2);
    run_one(1, tg, td, fl, di, ba);
    chk("PB_flag", 32'(fl), 1);
    chk("PB_latency", 32'(td - tg), 6);

    // Data wrap 1023 -> 0 fails.
    mem[80] = 10'd1023; mem[81] = 10'd0;
    set_desc(2, 80, 0, 2, 0);
    run_one(2, tg, td, fl, di, ba);
    chk("WO_flag", 32'(fl), 0);
    chk("WO_latency", 32'(td - tg), 4);

    // colIdx {4,4} and {4,3} both fail.
    mem[96] = 10'd4; mem[97] = 10'd4;
    set_desc(2, 0, 96, 0, 2);
    run_one(2, tg, td, fl, di, ba);
    chk("W44_flag", 32'(fl), 0);
    mem[100] = 10'd4; mem[101] = 10'd3;
    set_desc(3, 0, 100, 0, 2);
    run_one(3, tg, td, fl, di, ba);
    chk("W43_flag", 32'(fl), 0);
    chk("W43_id", 32'(di), 3);

    // All four requesting continuously; last grant was requester 3.
    set_desc(0, 0, 100, 0, 2);
    set_desc(1, 110, 120, 2, 2);
    set_desc(2, 0, 96, 0, 2);
    set_desc(3, 300, 400, 0, 0);
    viol = 0; ng = 0; nd = 0; tg5 = 0;
    @(posedge clk); #1;
    req = '1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (ng == 5 && cyc > tg5) req = '0;
      if (gnt != '0 && ng < 5) begin
        gv[ng] = int'(gnt);
        if (ng == 4) tg5 = cyc;
        ng = ng + 1;
      end
      if (done && nd < 5) begin
        dv[nd] = int'(done_id);
        fv[nd] = int'(flag);
        nd = nd + 1;
      end
      if (nd == 5) break;
    end
    req = '0;
    chk("RR_ngrants", 32'(ng), 5);
    chk("RR_ndone", 32'(nd), 5);
    chk("RR_g0", 32'(gv[0]), 1);
    chk("RR_g1", 32'(gv[1]), 2);
    chk("RR_g2", 32'(gv[2]), 4);
    chk("RR_g3", 32'(gv[3]), 8);
    chk("RR_g4", 32'(gv[4]), 1);
    chk("RR_id0", 32'(dv[0]), 0);
    chk("RR_id1", 32'(dv[1]), 1);
    chk("RR_id2", 32'(dv[2]), 2);
    chk("RR_id3", 32'(dv[3]), 3);
    chk("RR_id4", 32'(dv[4]), 0);
    chk("RR_f0", 32'(fv[0]), 0);
    chk("RR_f1", 32'(fv[1]), 1);
    chk("RR_f3", 32'(fv[3]), 1);
    chk("RR_flag_held", 32'(flag), 0);
    chk("RR_no_gnt_busy", 32'(viol), 0);

    // Reset during FETCH_COL.
    mem[130] = 10'd0; mem[131] = 10'd1;
    for (int i = 0; i < 5; i++) mem[140 + i] = WIDTH'(i);
    set_desc(1, 130, 140, 2, 5);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    req[1] = 1'b1;
    tg = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tg >= 0 && cyc > tg) req[1] = 1'b0;
      if (gnt[1] && tg < 0) tg = cyc;
      if (tg >= 0 && cyc == tg + 4) break;
    end
    req = '0;
    chk("RS_pre_rd_en", 32'(mem_rd_en), 1);
    chk("RS_pre_addr", 32'(mem_addr), 141);
    rst = 1'b0;
    #1;
    chk("RS_gnt", 32'(gnt), 0);
    chk("RS_rd_en", 32'(mem_rd_en), 0);
    chk("RS_busy", 32'(busy), 0);
    chk("RS_done", 32'(done), 0);
    chk("RS_flag", 32'(flag), 1);
    chk("RS_done_id", 32'(done_id), 0);
    dcount = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dcount = dcount + 1;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) dcount = dcount + 1;
    end
    chk("RS_no_done", 32'(dcount), 0);

    // After reset the pointer favours requester 0.
    ng = 0; nd = 0;
    tgv = '{0, 0}; tdv = '{0, 0};
    @(posedge clk); #1;
    req = 4'b0011;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ng >= 1 && cyc > tgv[0]) req[gv[0] == 1 ? 0 : 1] = 1'b0;
      if (ng >= 2 && cyc > tgv[1]) req = '0;
      if (gnt != '0 && ng < 2) begin
        gv[ng] = int'(gnt);
        tgv[ng] = cyc;
        ng = ng + 1;
      end
      if (done && nd < 2) begin
        dv[nd] = int'(done_id);
        fv[nd] = int'(flag);
        tdv[nd] = cyc;
        nd = nd + 1;
      end
      if (nd == 2) break;
    end
    req = '0;
    chk("PR_first_gnt", 32'(gv[0]), 1);
    chk("PR_second_gnt", 32'(gv[1]), 2);
    chk("PR_id0", 32'(dv[0]), 0);
    chk("PR_flag0", 32'(fv[0]), 0);
    chk("PR_lat0", 32'(tdv[0] - tgv[0]), 4);
    chk("PR_id1", 32'(dv[1]), 1);
    chk("PR_flag1", 32'(fv[1]), 1);
    chk("PR_lat1", 32'(tdv[1] - tgv[1]), 9);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
